// File: rtl/cpu65_bus_pkg.sv
// Shared types for 65C02 external-bus targets: responder states, float fill
// value and the phi2 edge pair.
package cpu65_bus_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_DONE,
    ST_WR_CAP,
    ST_WR_REQ
  } resp_state_t;

  localparam logic [7:0] BUS_FLOAT = 8'hFF;

  typedef struct packed {
    logic rise;
    logic fall;
  } phi2_edge_t;
endpackage

// File: rtl/phi2_edge_detect.sv
// Registers phi2 in the fclk domain and flags its rising/falling edges.
// The pulses are combinational against the registered copy.
module phi2_edge_detect
  import cpu65_bus_pkg::*;
(
  input  logic fclk,
  input  logic resb,
  input  logic phi2,
  output logic phi2_rise,
  output logic phi2_fall
);
  logic       phi2_q;
  phi2_edge_t edg;

  always_ff @(posedge fclk or negedge resb) begin
    if (!resb) phi2_q <= 1'b0;
    else       phi2_q <= phi2;
  end

  assign edg       = '{rise: phi2 & ~phi2_q, fall: ~phi2 & phi2_q};
  assign phi2_rise = edg.rise;
  assign phi2_fall = edg.fall;
endmodule

// File: rtl/bus_target_responder.sv
// Target end of the 65C02 data bus: serves reads/writes inside a 2^WIN_W window
// through a req/ack memory port, stalling the core via RDY while reads are pending.
module bus_target_responder
  import cpu65_bus_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h8000,
  parameter int          WIN_W     = 12,
  parameter int          MAX_WAIT  = 15
) (
  input  logic             fclk,
  input  logic             resb,
  input  logic             phi2,
  input  logic             rwb,
  input  logic             be,
  input  logic [15:0]      addr,
  input  logic [7:0]       data_in,
  output logic [7:0]       data_out,
  output logic             data_oe,
  output logic             rdy,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIN_W-1:0] mem_addr,
  output logic [7:0]       mem_wdata,
  input  logic [7:0]       mem_rdata,
  input  logic             mem_ack,
  output logic             bus_err
);
  localparam logic [7:0] MAX_W8 = 8'(MAX_WAIT);

  resp_state_t state;
  logic        served;
  logic [7:0]  wait_cnt, cnt_inc;
  logic [7:0]  rd_buf;
  logic        hit, timeout;
  logic        phi2_fall, phi2_rise_unused;

  phi2_edge_detect u_edge (
    .fclk      (fclk),
    .resb      (resb),
    .phi2      (phi2),
    .phi2_rise (phi2_rise_unused),
    .phi2_fall (phi2_fall)
  );

  assign hit      = be && (addr[15:WIN_W] == BASE_ADDR[15:WIN_W]);
  assign cnt_inc  = wait_cnt + 8'd1;
  assign timeout  = (cnt_inc == MAX_W8);
  assign data_out = rd_buf;
  assign data_oe  = (state == ST_RD_DONE) && phi2 && be && rwb;
  // A new targeted cycle arriving while a posted write drains is held off.
  assign rdy      = !((state == ST_RD_WAIT) || ((state == ST_WR_REQ) && phi2 && hit));

  always_ff @(posedge fclk or negedge resb) begin
    if (!resb) begin
      state     <= ST_IDLE;
      served    <= 1'b0;
      wait_cnt  <= 8'd0;
      rd_buf    <= 8'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'd0;
      bus_err   <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      if (phi2_fall) served <= 1'b0;
      case (state)
        ST_IDLE: if (phi2 && hit && !served) begin
          mem_addr <= addr[WIN_W-1:0];
          served   <= 1'b1;
          if (rwb) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            wait_cnt <= 8'd0;
            state    <= ST_RD_WAIT;
          end else begin
            state <= ST_WR_CAP;
          end
        end
        // phi2 falling here is ignored: the core repeats the stalled cycle.
        ST_RD_WAIT: begin
          wait_cnt <= cnt_inc;
          if (mem_ack) begin
            rd_buf  <= mem_rdata;
            mem_req <= 1'b0;
            state   <= ST_RD_DONE;
          end else if (timeout) begin
            rd_buf  <= BUS_FLOAT;
            bus_err <= 1'b1;
            mem_req <= 1'b0;
            state   <= ST_RD_DONE;
          end
        end
        ST_RD_DONE: if (phi2_fall) state <= ST_IDLE;
        ST_WR_CAP: if (phi2_fall) begin
          mem_wdata <= data_in;
          mem_req   <= 1'b1;
          mem_we    <= 1'b1;
          wait_cnt  <= 8'd0;
          state     <= ST_WR_REQ;
        end
        ST_WR_REQ: begin
          wait_cnt <= cnt_inc;
          if (mem_ack || timeout) begin
            bus_err <= !mem_ack;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_target_responder.sv
// Directed bench for bus_target_responder: reads, posted writes, non-hit
// cycles, timeout, back-to-back drain stall and mid-transaction reset.
module tb_bus_target_responder;
  logic        fclk = 1'b0;
  logic        resb;
  logic        phi2 = 1'b0, rwb = 1'b1, be = 1'b0;
  logic [15:0] addr = 16'h0;
  logic [7:0]  data_in = 8'h0, mem_rdata = 8'h0;
  logic        mem_ack = 1'b0;
  logic [7:0]  data_out, mem_wdata;
  logic        data_oe, rdy, mem_req, mem_we, bus_err;
  logic [11:0] mem_addr;
  int          checks = 0, errors = 0;

  bus_target_responder #(.BASE_ADDR(16'h8000), .WIN_W(12), .MAX_WAIT(15)) dut (
    .fclk(fclk), .resb(resb), .phi2(phi2), .rwb(rwb), .be(be), .addr(addr),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe), .rdy(rdy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
  );

  always #5 fclk = ~fclk;

  task automatic cyc();
    @(posedge fclk); #1;
  endtask

  task automatic test_reset();
    resb = 1'b1; #1; resb = 1'b0; #1;
    checks++; if ({rdy, data_oe, mem_req, mem_we, bus_err} !== 5'b10000) begin errors++; $display("FAIL reset_ctl got %b exp 10000", {rdy, data_oe, mem_req, mem_we, bus_err}); end
    checks++; if ({mem_addr, mem_wdata, data_out} !== 28'h0) begin errors++; $display("FAIL reset_data got %h exp 0", {mem_addr, mem_wdata, data_out}); end
    cyc(); resb = 1'b1; cyc();
  endtask

  task automatic test_read();
    int low = 0;
    be = 1; rwb = 1; addr = 16'h8123; phi2 = 1;
    cyc();
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'h123) begin errors++; $display("FAIL rd_req got req=%b we=%b a=%h exp 1 0 123", mem_req, mem_we, mem_addr); end
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) begin mem_ack = 1; mem_rdata = 8'hA5; end
      #1; if (!rdy) low++;
      cyc(); mem_ack = 0;
    end
    checks++; if (low != 3) begin errors++; $display("FAIL rd_rdy_low got %0d exp 3", low); end
    checks++; if ({rdy, mem_req, data_oe} !== 3'b101 || data_out !== 8'hA5) begin errors++; $display("FAIL rd_done got rdy/req/oe=%b d=%h exp 101 a5", {rdy, mem_req, data_oe}, data_out); end
    phi2 = 0; #1;
    checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL rd_oe_low got %b exp 0", data_oe); end
    cyc(); cyc();
  endtask

  task automatic test_write();
    int low = 0;
    addr = 16'h8FFF; rwb = 0; data_in = 8'h3C; phi2 = 1;
    for (int i = 0; i < 2; i++) begin #1; if (!rdy) low++; cyc(); end
    checks++; if (mem_req !== 1'b0 || mem_addr !== 12'hFFF) begin errors++; $display("FAIL wr_cap got req=%b a=%h exp 0 fff", mem_req, mem_addr); end
    phi2 = 0; cyc(); data_in = 8'h00;
    checks++; if ({mem_req, mem_we} !== 2'b11 || mem_wdata !== 8'h3C) begin errors++; $display("FAIL wr_req got rq/we=%b wd=%h exp 11 3c", {mem_req, mem_we}, mem_wdata); end
    if (!rdy) low++;
    mem_ack = 1; cyc(); mem_ack = 0;
    if (!rdy) low++;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL wr_drain got %b exp 0", mem_req); end
    checks++; if (low != 0) begin errors++; $display("FAIL wr_rdy_low got %0d exp 0", low); end
    cyc();
  endtask

  task automatic test_nonhit();
    int bad = 0;
    rwb = 1; be = 1; addr = 16'h7FFF; phi2 = 1;
    for (int i = 0; i < 3; i++) begin cyc(); if ({mem_req, rdy, data_oe} !== 3'b010) bad++; end
    phi2 = 0; cyc(); be = 0; addr = 16'h8123; phi2 = 1;
    for (int i = 0; i < 3; i++) begin cyc(); if ({mem_req, rdy, data_oe} !== 3'b010) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL nonhit got %0d bad cycles exp 0", bad); end
    mem_ack = 1; mem_rdata = 8'h55; cyc(); mem_ack = 0;
    checks++; if (data_out !== 8'hA5 || mem_req !== 1'b0) begin errors++; $display("FAIL stray_ack got d=%h req=%b exp a5 0", data_out, mem_req); end
    phi2 = 0; cyc();
  endtask

  task automatic test_timeout();
    int low = 0; bit seen = 0;
    be = 1; rwb = 1; addr = 16'h8010; phi2 = 1;
    cyc();
    for (int i = 0; i < 40; i++) begin
      if (bus_err) begin seen = 1; break; end
      if (!rdy) low++;
      cyc();
    end
    checks++; if (!seen || low != 15) begin errors++; $display("FAIL timeout got seen=%b low=%0d exp 1 15", seen, low); end
    checks++; if (data_out !== 8'hFF || {rdy, mem_req, data_oe} !== 3'b101) begin errors++; $display("FAIL to_done got d=%h rdy/req/oe=%b exp ff 101", data_out, {rdy, mem_req, data_oe}); end
    cyc();
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL to_pulse got %b exp 0", bus_err); end
    phi2 = 0; cyc(); cyc();
  endtask

  task automatic test_back_to_back();
    int low = 0, reqs = 0;
    addr = 16'h8200; rwb = 0; data_in = 8'h77; phi2 = 1;
    cyc(); phi2 = 0; cyc();
    addr = 16'h8300; rwb = 1; phi2 = 1;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) mem_ack = 1;
      #1; if (!rdy) low++;
      cyc(); mem_ack = 0;
    end
    checks++; if (low != 5 || mem_req !== 1'b0 || rdy !== 1'b1) begin errors++; $display("FAIL b2b_drain got low=%0d req=%b rdy=%b exp 5 0 1", low, mem_req, rdy); end
    cyc();
    checks++; if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 12'h300 || rdy !== 1'b0) begin errors++; $display("FAIL b2b_rd got rq/we=%b a=%h rdy=%b exp 10 300 0", {mem_req, mem_we}, mem_addr, rdy); end
    mem_ack = 1; mem_rdata = 8'h5A; cyc(); mem_ack = 0;
    for (int i = 0; i < 3; i++) begin if (mem_req) reqs++; cyc(); end
    checks++; if (reqs != 0 || data_out !== 8'h5A || data_oe !== 1'b1 || rdy !== 1'b1) begin errors++; $display("FAIL b2b_once got reqs=%0d d=%h oe=%b rdy=%b exp 0 5a 1 1", reqs, data_out, data_oe, rdy); end
    phi2 = 0; cyc(); cyc();
  endtask

  task automatic test_reset_mid();
    addr = 16'h8040; rwb = 1; phi2 = 1;
    cyc(); cyc();
    checks++; if (mem_req !== 1'b1 || rdy !== 1'b0) begin errors++; $display("FAIL rst_pre got req=%b rdy=%b exp 1 0", mem_req, rdy); end
    #2; resb = 0; #1;
    checks++; if ({mem_req, rdy, bus_err} !== 3'b010 || data_out !== 8'h00) begin errors++; $display("FAIL rst_mid got req/rdy/err=%b d=%h exp 010 00", {mem_req, rdy, bus_err}, data_out); end
    phi2 = 0; cyc(); resb = 1; cyc();
    checks++; if (mem_req !== 1'b0 || rdy !== 1'b1) begin errors++; $display("FAIL rst_idle got req=%b rdy=%b exp 0 1", mem_req, rdy); end
    addr = 16'h8041; phi2 = 1; cyc();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 12'h041) begin errors++; $display("FAIL rst_reaccept got req=%b a=%h exp 1 041", mem_req, mem_addr); end
    mem_ack = 1; mem_rdata = 8'h12; cyc(); mem_ack = 0;
    checks++; if (data_out !== 8'h12 || rdy !== 1'b1) begin errors++; $display("FAIL zero_wait got d=%h rdy=%b exp 12 1", data_out, rdy); end
    phi2 = 0; cyc();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_nonhit();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
